// File: rtl/seq_step_ctrl.sv
// Command sequencer for the scrambled 16-state up/down counter: runs LOAD, STEP
// and SEEK commands, paces CE pulses by a programmable divider and reports status.
module seq_step_ctrl #(
    parameter int CNT_W    = 5,
    parameter int DIV_W    = 8,
    parameter int MAX_SEEK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic [DIV_W-1:0] div,
    input  logic             abort,
    input  logic [3:0]       fsm_data,
    output logic             fsm_ce,
    output logic             fsm_up,
    output logic             fsm_load,
    output logic [3:0]       fsm_dat,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] steps_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LDO,
        S_WAIT,
        S_PULSE,
        S_CHECK,
        S_FIN
    } state_t;

    localparam logic [1:0]       OP_NOP  = 2'b00;
    localparam logic [1:0]       OP_LOAD = 2'b01;
    localparam logic [1:0]       OP_STEP = 2'b10;
    localparam logic [1:0]       OP_SEEK = 2'b11;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SEEK);

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] arg_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] wait_cnt;
    logic             accept;
    logic             seek_expire;
    state_t           pace_state;

    assign accept = cmd_valid && (state == S_IDLE);

    // A zero divider skips WAIT entirely so the step period stays DIV+2.
    assign pace_state = (div_q == '0) ? S_PULSE : S_WAIT;

    assign seek_expire = (state == S_CHECK) && !abort && (op_q == OP_SEEK) &&
                         (fsm_data != arg_q[3:0]) && (steps_done == MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_NOP:  state_nxt = S_FIN;
                        OP_LOAD: state_nxt = S_LDO;
                        OP_STEP: begin
                            if (cmd_arg == '0)
                                state_nxt = S_FIN;
                            else if (div == '0)
                                state_nxt = S_PULSE;
                            else
                                state_nxt = S_WAIT;
                        end
                        default: state_nxt = S_CHECK;
                    endcase
                end
            end
            S_LDO: state_nxt = S_FIN;
            S_WAIT: begin
                if (abort)
                    state_nxt = S_FIN;
                else if (wait_cnt == div_q - DIV_W'(1))
                    state_nxt = S_PULSE;
            end
            S_PULSE: state_nxt = abort ? S_FIN : S_CHECK;
            S_CHECK: begin
                if (abort) begin
                    state_nxt = S_FIN;
                end else if (op_q == OP_STEP) begin
                    state_nxt = (steps_done == arg_q) ? S_FIN : pace_state;
                end else if (fsm_data == arg_q[3:0]) begin
                    state_nxt = S_FIN;
                end else if (steps_done == MAX_CNT) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = pace_state;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command fields, direction and status live from one accept to the next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= OP_NOP;
            arg_q      <= '0;
            div_q      <= '0;
            fsm_up     <= 1'b0;
            steps_done <= '0;
            timeout    <= 1'b0;
        end else if (accept) begin
            op_q       <= cmd_op;
            arg_q      <= cmd_arg;
            div_q      <= div;
            fsm_up     <= cmd_dir;
            steps_done <= '0;
            timeout    <= 1'b0;
        end else begin
            if (state == S_PULSE)
                steps_done <= steps_done + CNT_W'(1);
            if (seek_expire)
                timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT) begin
            wait_cnt <= wait_cnt + DIV_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FIN);
    assign fsm_ce    = (state == S_PULSE);
    assign fsm_load  = (state == S_LDO);
    assign fsm_dat   = (state == S_LDO) ? arg_q[3:0] : 4'h0;

endmodule

// File: tb/tb_seq_step_ctrl.sv
// Bench for seq_step_ctrl: a behavioural counter closes the loop, and every
// command is predicted from the counter's value table with plain arithmetic.
module tb_seq_step_ctrl;

    localparam int CNT_W    = 5;
    localparam int DIV_W    = 8;
    localparam int MAX_SEEK = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_arg = '0;
    logic [DIV_W-1:0] div = '0;
    logic             abort = 1'b0;
    logic [3:0]       fsm_data;
    logic             fsm_ce;
    logic             fsm_up;
    logic             fsm_load;
    logic [3:0]       fsm_dat;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] steps_done;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] cnt_idx;
    logic [3:0] ref_idx = 4'd0;

    seq_step_ctrl #(.CNT_W(CNT_W), .DIV_W(DIV_W), .MAX_SEEK(MAX_SEEK)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dir(cmd_dir), .cmd_arg(cmd_arg), .div(div),
        .abort(abort), .fsm_data(fsm_data), .fsm_ce(fsm_ce), .fsm_up(fsm_up),
        .fsm_load(fsm_load), .fsm_dat(fsm_dat), .busy(busy), .done(done),
        .timeout(timeout), .steps_done(steps_done)
    );

    always #5 clk = ~clk;

    // Counter output sequence by state index; 1,2,3,4,A,B never appear.
    function automatic logic [3:0] seq_val(input logic [3:0] i);
        case (i)
            4'd0: return 4'h5;  4'd1: return 4'hC;  4'd2: return 4'h0;  4'd3: return 4'h8;
            4'd4: return 4'h6;  4'd5: return 4'h7;  4'd6: return 4'h9;  4'd7: return 4'hD;
            4'd8: return 4'hE;  4'd9: return 4'hF;  4'd10: return 4'h0; 4'd11: return 4'h8;
            4'd12: return 4'h6; 4'd13: return 4'hC; 4'd14: return 4'h9; default: return 4'h7;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_idx <= 4'd0;
        else if (fsm_load)
            cnt_idx <= fsm_dat;
        else if (fsm_ce)
            cnt_idx <= fsm_up ? cnt_idx + 4'd1 : cnt_idx - 4'd1;
    end
    assign fsm_data = seq_val(cnt_idx);

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Predicts latency (cycles from accept to DONE), pulse count and timeout.
    task automatic ref_model(input logic [1:0] op, input logic dir, input logic [CNT_W-1:0] arg,
                             input logic [DIV_W-1:0] dv, output int e_lat, output int e_ce,
                             output int e_to);
        int per;
        per   = int'(dv) + 2;
        e_lat = 1;
        e_ce  = 0;
        e_to  = 0;
        case (op)
            2'b01: begin
                e_lat   = 2;
                ref_idx = arg[3:0];
            end
            2'b10: begin
                e_ce = int'(arg);
                if (e_ce != 0) e_lat = e_ce * per + 1;
                for (int i = 0; i < e_ce; i++) ref_idx = dir ? ref_idx + 4'd1 : ref_idx - 4'd1;
            end
            2'b11: begin
                while (seq_val(ref_idx) != arg[3:0] && e_ce < MAX_SEEK) begin
                    ref_idx = dir ? ref_idx + 4'd1 : ref_idx - 4'd1;
                    e_ce++;
                end
                e_to  = (seq_val(ref_idx) != arg[3:0]) ? 1 : 0;
                e_lat = e_ce * per + 2;
            end
            default: ;
        endcase
    endtask

    task automatic issue_cmd(input logic [1:0] op, input logic dir, input logic [CNT_W-1:0] arg,
                             input logic [DIV_W-1:0] dv);
        int w;
        w = 0;
        @(negedge clk);
        while (!cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check_output("ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dir   = dir;
        cmd_arg   = arg;
        div       = dv;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_dir   = 1'($urandom);
        cmd_arg   = CNT_W'($urandom);
        div       = DIV_W'($urandom);
    endtask

    task automatic apply_stimulus(input logic [1:0] op, input logic dir,
                                  input logic [CNT_W-1:0] arg, input logic [DIV_W-1:0] dv);
        int e_lat, e_ce, e_to, e_steps;
        int lat, ce_n, ld_n, gap_bad, ovl, last_ce, load_lat, load_dat;
        bit seen_done;
        ref_model(op, dir, arg, dv, e_lat, e_ce, e_to);
        e_steps = e_ce;
        issue_cmd(op, dir, arg, dv);
        lat = 0; ce_n = 0; ld_n = 0; gap_bad = 0; ovl = 0; last_ce = -1;
        load_lat = 0; load_dat = 0; seen_done = 0;
        while (!seen_done && lat < 3000) begin
            @(negedge clk);
            lat++;
            if (fsm_ce) begin
                if (last_ce >= 0 && (lat - last_ce) != int'(dv) + 2) gap_bad++;
                last_ce = lat;
                ce_n++;
            end
            if (fsm_load) begin
                ld_n++;
                load_lat = lat;
                load_dat = int'(fsm_dat);
            end
            if (fsm_ce && fsm_load) ovl++;
            if (done) seen_done = 1;
        end
        check_output("done_seen", seen_done, 1);
        check_output("latency", lat, e_lat);
        check_output("ce_count", ce_n, e_ce);
        check_output("load_count", ld_n, (op == 2'b01) ? 1 : 0);
        check_output("ce_spacing", gap_bad, 0);
        check_output("ce_load_overlap", ovl, 0);
        check_output("busy_in_fin", busy, 1);
        check_output("up_in_fin", fsm_up, dir);
        if (op == 2'b01) begin
            check_output("load_cycle", load_lat, 1);
            check_output("load_data", load_dat, arg[3:0]);
        end
        @(negedge clk);
        check_output("done_one_cycle", done, 0);
        check_output("ready_after", cmd_ready, 1);
        check_output("steps_done", steps_done, e_steps);
        check_output("timeout", timeout, e_to);
        check_output("counter_value", fsm_data, seq_val(ref_idx));
        check_output("up_holds", fsm_up, dir);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        ref_idx   = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_output("rst_ready", cmd_ready, 1);
        check_output("rst_busy", busy, 0);
        check_output("rst_outputs", {fsm_ce, fsm_load, fsm_up, fsm_dat, done, timeout}, 0);
        check_output("rst_steps", steps_done, 0);
        check_output("rst_counter", fsm_data, 4'h5);
    endtask

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, cyc, extra_ce, done_n;

        do_reset();
        apply_stimulus(2'b01, 1'b1, 5'd3, 8'd0);

        do_reset();
        apply_stimulus(2'b10, 1'b1, 5'd3, 8'd2);

        do_reset();
        apply_stimulus(2'b11, 1'b1, 5'd6, 8'd0);

        do_reset();
        apply_stimulus(2'b11, 1'b1, 5'hA, 8'd0);

        do_reset();
        apply_stimulus(2'b11, 1'b0, 5'd5, 8'd3);
        apply_stimulus(2'b10, 1'b1, 5'd0, 8'd4);
        apply_stimulus(2'b00, 1'b0, 5'd9, 8'd1);
        apply_stimulus(2'b10, 1'b0, 5'd5, 8'd0);

        // Abort after the second pulse of a long STEP.
        issue_cmd(2'b10, 1'b1, 5'd10, 8'd1);
        n = 0;
        cyc = 0;
        while (n < 2 && cyc < 200) begin
            @(negedge clk);
            if (fsm_ce) n++;
            cyc++;
        end
        check_output("abort_wait", n, 2);
        @(negedge clk);
        abort = 1'b1;
        extra_ce = 0;
        done_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            abort = 1'b0;
            if (fsm_ce) extra_ce++;
            if (done) done_n++;
        end
        ref_idx = ref_idx + 4'd2;
        check_output("abort_no_ce", extra_ce, 0);
        check_output("abort_done", done_n, 1);
        check_output("abort_steps", steps_done, 2);
        check_output("abort_ready", cmd_ready, 1);
        check_output("abort_counter", fsm_data, seq_val(ref_idx));

        // Asynchronous reset in the middle of a WAIT.
        issue_cmd(2'b10, 1'b1, 5'd10, 8'd5);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("midrst_outputs", {fsm_ce, fsm_load, fsm_up, fsm_dat, done, timeout, busy}, 0);
        check_output("midrst_steps", steps_done, 0);
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            if (done) done_n++;
        end
        ref_idx = 4'd0;
        check_output("midrst_no_done", done_n, 0);
        check_output("midrst_ready", cmd_ready, 1);
        check_output("midrst_counter", fsm_data, 4'h5);

        for (int i = 0; i < 25; i++) begin
            apply_stimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                           CNT_W'($urandom_range(0, 31)), DIV_W'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
